ram_sweep_clear: RTL and testbench

- Parametrised single-port data RAM for the model computer; it is the successor to the fixed 256x8 RAM.
- Replaces the parallel reset of every word with a sequential hardware clear sweep, one word per cycle.
- Reads are synchronous and registered, with a valid strobe.
- Adds a busy flag, a software-triggered clear, and out-of-range and access-while-busy error reporting.
- Sits between the CPU datapath (address/data bus) and the control unit.

---
 rtl/ram_sweep_clear_pkg.sv | 21 ++
 rtl/ram_sweep_clear_if.sv | 27 ++
 rtl/ram_sweep_clear_array.sv | 31 +++
 rtl/ram_sweep_clear.sv | 105 ++++++++++
 tb/tb_ram_sweep_clear.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ram_sweep_clear_pkg.sv
// rtl/ram_sweep_clear_pkg.sv - shared types and helpers for the model-computer data RAM
package ram_sweep_clear_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ram_sweep_clear_if.sv
// rtl/ram_sweep_clear_if.sv - CPU-side request/response bus of the data RAM
interface ram_sweep_clear_if
   import ram_sweep_clear_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              clear;
   logic              rd_en;
   logic              wr_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              busy;
   logic              err;

   modport master (
      output clear, rd_en, wr_en, addr, wdata,
      input  rdata, rvalid, busy, err
   );

   modport slave (
      input  clear, rd_en, wr_en, addr, wdata,
      output rdata, rvalid, busy, err
   );
endinterface

// File: rtl/ram_sweep_clear_array.sv
// rtl/ram_sweep_clear_array.sv - single write port memory with registered read
module ram_sweep_clear_array #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   input  logic              fwd,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset; the sweep initialises it.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (re) begin
         q <= fwd ? wdata : mem[raddr];
      end
   end
endmodule

// File: rtl/ram_sweep_clear.sv
// rtl/ram_sweep_clear.sv - data RAM with sequential clear sweep, busy flag and error pulses
module ram_sweep_clear
   import ram_sweep_clear_pkg::*;
#(
   parameter int              DATA_W   = DEF_DATA_W,
   parameter int              ADDR_W   = DEF_ADDR_W,
   parameter int              DEPTH    = 256,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input logic         clk,
   input logic         rst,
   ram_sweep_clear_if.slave bus
);
   localparam int              CNT_W   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W-1:0]  idx;
   logic              idle, in_range, req, rd_ok, wr_ok;
   logic              mem_we;
   logic [CNT_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_q;
   logic              busy;
   logic              rvalid_q, err_q;

   // Extra bit keeps DEPTH == 2**ADDR_W representable.
   assign in_range = {1'b0, bus.addr} < DEPTH_X;
   assign idx      = bus.addr[CNT_W-1:0];
   assign idle     = (state == ST_IDLE);
   assign req      = bus.rd_en | bus.wr_en;
   assign rd_ok    = idle & ~bus.clear & bus.rd_en & in_range;
   assign wr_ok    = idle & ~bus.clear & bus.wr_en & in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = idx;
      mem_wdata = bus.wdata;
      case (state)
         ST_CLEAR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = INIT_VAL;
            if (cnt == LAST) state_nxt = ST_IDLE;
            else             cnt_nxt   = cnt + CNT_W'(1);
         end
         ST_IDLE: begin
            mem_we = wr_ok;
            if (bus.clear) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   // Single port: a simultaneous read and write always hit the same word, so read returns wdata.
   ram_sweep_clear_array #(
      .DATA_W (DATA_W),
      .IDX_W  (CNT_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (rd_ok),
      .raddr (idx),
      .fwd   (wr_ok),
      .q     (mem_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= rd_ok;
         err_q    <= req & ~(rd_ok | wr_ok);
      end
   end

   assign bus.rdata  = mem_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign bus.busy   = busy;
endmodule

// File: tb/tb_ram_sweep_clear.sv
// tb/tb_ram_sweep_clear.sv - self-checking bench for ram_sweep_clear (DEPTH 256 and 200)
module tb_ram_sweep_clear;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_sweep_clear_if #(.DATA_W(8), .ADDR_W(8)) bus_a ();
   ram_sweep_clear_if #(.DATA_W(8), .ADDR_W(8)) bus_b ();

   ram_sweep_clear #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_VAL(8'hA5)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave));
   ram_sweep_clear #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_VAL(8'h5A)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave));

   int         passed = 0;
   int         total  = 0;
   logic [7:0] mem_a [256];
   logic [7:0] mem_b [200];
   logic [7:0] exp_rd [2];
   int         n, n_a, n_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int w, input logic clr, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
      if (w == 0) begin
         bus_a.clear = clr; bus_a.rd_en = rd; bus_a.wr_en = wr; bus_a.addr = a; bus_a.wdata = d;
      end else begin
         bus_b.clear = clr; bus_b.rd_en = rd; bus_b.wr_en = wr; bus_b.addr = a; bus_b.wdata = d;
      end
   endtask

   task automatic fill_models();
      for (int i = 0; i < 256; i++) mem_a[i] = 8'hA5;
      for (int i = 0; i < 200; i++) mem_b[i] = 8'h5A;
   endtask

   // One request to an idle RAM, checked against the reference arrays.
   task automatic op(input int w, input logic clr, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [7:0] d, input string tag);
      int   depth;
      logic ok, exp_rv, exp_err;
      depth   = (w == 0) ? 256 : 200;
      ok      = !clr && (int'(a) < depth);
      exp_rv  = rd && ok;
      exp_err = (rd || wr) && !ok;
      if (ok && wr) begin
         if (w == 0) mem_a[a] = d;
         else        mem_b[a] = d;
      end
      if (exp_rv) exp_rd[w] = (w == 0) ? mem_a[a] : mem_b[a];
      drive(w, clr, rd, wr, a, d);
      step();
      drive(w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (w == 0) begin
         chk({tag, "_rvalid_a"}, bus_a.rvalid, exp_rv);
         chk({tag, "_err_a"},    bus_a.err,    exp_err);
         chk({tag, "_rdata_a"},  bus_a.rdata,  exp_rd[0]);
      end else begin
         chk({tag, "_rvalid_b"}, bus_b.rvalid, exp_rv);
         chk({tag, "_err_b"},    bus_b.err,    exp_err);
         chk({tag, "_rdata_b"},  bus_b.rdata,  exp_rd[1]);
      end
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      rst = 1'b1;
      repeat (3) step();
      chk("rst_busy_a",   bus_a.busy,   1'b1);
      chk("rst_busy_b",   bus_b.busy,   1'b1);
      chk("rst_rvalid_a", bus_a.rvalid, 1'b0);
      chk("rst_err_a",    bus_a.err,    1'b0);
      chk("rst_rdata_a",  bus_a.rdata,  8'h00);

      // Power-up sweep length.
      rst = 1'b0;
      n_a = 0; n_b = 0;
      for (int c = 0; c < 2000 && (bus_a.busy || bus_b.busy); c++) begin
         n_a += int'(bus_a.busy);
         n_b += int'(bus_b.busy);
         step();
      end
      chk("sweep_len_a", n_a, 256);
      chk("sweep_len_b", n_b, 200);
      fill_models();

      op(0, 0, 1, 0, 8'd0,   8'h00, "init_rd0");
      op(0, 0, 1, 0, 8'd128, 8'h00, "init_rd128");
      op(0, 0, 1, 0, 8'd255, 8'h00, "init_rd255");

      op(0, 0, 0, 1, 8'h10, 8'h3C, "wr10");
      op(0, 0, 1, 0, 8'h10, 8'h00, "rd10");
      op(0, 0, 0, 0, 8'h00, 8'h00, "hold10");

      op(0, 0, 1, 1, 8'h20, 8'h77, "rdwr20");
      op(0, 0, 0, 0, 8'h00, 8'h00, "hold20");
      op(0, 0, 1, 0, 8'h20, 8'h00, "rd20");

      op(1, 0, 0, 1, 8'd210, 8'hFF, "oor_wr210");
      op(1, 0, 1, 0, 8'd210, 8'h00, "oor_rd210");
      op(1, 0, 0, 1, 8'd199, 8'h42, "wr199");
      op(1, 0, 1, 0, 8'd199, 8'h00, "rd199");
      op(1, 0, 1, 0, 8'd200, 8'h00, "oor_rd200");

      for (int i = 0; i < 300; i++) begin
         op(int'($urandom_range(0, 1)), 1'b0, 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), "rand");
      end

      // Software clear, with a blocked write and an ignored clear mid-sweep.
      op(0, 1, 0, 0, 8'h00, 8'h00, "clear_start");
      n = 0;
      for (int c = 0; c < 2000 && bus_a.busy; c++) begin
         n++;
         if (n == 5)       drive(0, 1'b0, 1'b0, 1'b1, 8'h33, 8'h99);
         else if (n == 10) drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
         else              drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         step();
         drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         chk("busy_err", bus_a.err, n == 5);
      end
      chk("sweep_len_clear", n, 256);
      for (int i = 0; i < 256; i++) mem_a[i] = 8'hA5;
      for (int i = 0; i < 256; i++) op(0, 0, 1, 0, 8'(i), 8'h00, "clear_rd");

      for (int i = 0; i < 40; i++) op(0, 0, 0, 1, 8'($urandom), 8'($urandom), "dirty");

      // Reset in the middle of a sweep restarts it from the start.
      op(0, 1, 0, 0, 8'h00, 8'h00, "clear2_start");
      repeat (99) step();
      chk("mid_busy_a", bus_a.busy, 1'b1);
      rst = 1'b1;
      step();
      step();
      chk("rst2_busy_a",   bus_a.busy,   1'b1);
      chk("rst2_rdata_a",  bus_a.rdata,  8'h00);
      chk("rst2_rvalid_a", bus_a.rvalid, 1'b0);
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      rst = 1'b0;
      n_a = 0; n_b = 0;
      for (int c = 0; c < 2000 && (bus_a.busy || bus_b.busy); c++) begin
         n_a += int'(bus_a.busy);
         n_b += int'(bus_b.busy);
         step();
      end
      chk("sweep_len_rst_a", n_a, 256);
      chk("sweep_len_rst_b", n_b, 200);
      fill_models();
      for (int i = 0; i < 256; i++) op(0, 0, 1, 0, 8'(i), 8'h00, "rst_rd_a");
      for (int i = 0; i < 50; i++) op(1, 0, 1, 0, 8'($urandom_range(0, 199)), 8'h00, "rst_rd_b");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
